// File: rtl/sys_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_pkg
// Description : Shared types and helpers for the systolic-array result path.
//               - state_t     : drain FSM states (IDLE, SEND, GAP)
//               - idx_width() : index width, max(1, $clog2(n))
//               - elem_count(): number of result elements in a matrix
// Revision    : 1.0 - initial release
// ============================================================================
package sys_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Default array geometry and the element count it implies.
    localparam int c_DEF_ARRAY_W   = 4;
    localparam int c_DEF_ARRAY_L   = 4;
    localparam int c_ELEM_COUNT    = c_DEF_ARRAY_W * c_DEF_ARRAY_L;

    // A 1-entry dimension still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int elem_count(input int w, input int l);
        return w * l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_array_pace_counter.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_pace_counter
// Description : Loadable down-counter that times the idle gap between two
//               streamed result elements. Loaded when an element is accepted,
//               counts while the reader sits in its gap state, and raises
//               o_expire on the last gap cycle.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               i_load     - reload the counter (element just accepted)
//               i_count_en - decrement while in the gap state
//               o_expire   - counter reached zero: gap ends this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sys_array_pace_counter #(
    parameter int CLOCK_DIVIDE = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_count_en,
    output logic o_expire
);

    localparam int c_CNT_W    = (CLOCK_DIVIDE < 1) ? 1 : CLOCK_DIVIDE;
    // The gap lasts 2**CLOCK_DIVIDE-1 cycles and the expiring cycle is one of
    // them, so the counter starts one below that.
    localparam int c_LOAD_VAL = (CLOCK_DIVIDE < 1) ? 0 : (2 ** CLOCK_DIVIDE) - 2;

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_CNT_W'(c_LOAD_VAL);
        end else if (i_count_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sys_array_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_result_reader
// Description : Captures the ARRAY_W x ARRAY_L result matrix of the systolic
//               array on comp_done and streams it out row-major over a
//               valid/ready interface, with 2**CLOCK_DIVIDE-1 idle cycles
//               between elements so a slow consumer can follow.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               comp_done  - one-cycle pulse, res_data valid
//               res_data   - flat matrix, (r,c) at [(r*ARRAY_L+c)*RES_WIDTH +: RES_WIDTH]
//               out_ready  - consumer accepts the current element
//               out_valid  - out_data/out_row/out_col valid
//               out_data   - current element
//               out_row    - row index of current element
//               out_col    - column index of current element
//               busy       - drain in progress
//               drain_done - one-cycle pulse after the last element is accepted
//               overrun    - sticky: comp_done seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module sys_array_result_reader
    import sys_array_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int RES_WIDTH    = 4 * DATA_WIDTH,
    parameter  int ARRAY_W      = 4,
    parameter  int ARRAY_L      = 4,
    parameter  int CLOCK_DIVIDE = 2,
    localparam int c_ROW_W      = idx_width(ARRAY_W),
    localparam int c_COL_W      = idx_width(ARRAY_L)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 comp_done,
    input  logic [ARRAY_W*ARRAY_L*RES_WIDTH-1:0] res_data,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [RES_WIDTH-1:0]                 out_data,
    output logic [c_ROW_W-1:0]                   out_row,
    output logic [c_COL_W-1:0]                   out_col,
    output logic                                 busy,
    output logic                                 drain_done,
    output logic                                 overrun
);

    localparam int                   c_ELEMS    = elem_count(ARRAY_W, ARRAY_L);
    localparam int                   c_IDX_W    = idx_width(c_ELEMS);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(c_ELEMS - 1);
    localparam logic [c_COL_W-1:0]   c_LAST_COL = c_COL_W'(ARRAY_L - 1);

    state_t               r_state;
    logic [RES_WIDTH-1:0] r_buf [c_ELEMS];
    logic [c_IDX_W-1:0]   r_idx;

    logic                 w_handshake;
    logic                 w_last;
    logic                 w_gap_load;
    logic                 w_gap_expire;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic [c_ROW_W-1:0]   w_row_next;
    logic [c_COL_W-1:0]   w_col_next;

    assign w_handshake = (r_state == ST_SEND) && out_valid && out_ready;
    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_gap_load  = w_handshake && !w_last;
    assign w_idx_next  = r_idx + 1'b1;

    // Row-major successor of the current (row, col).
    always_comb begin
        w_row_next = out_row;
        w_col_next = out_col + 1'b1;
        if (out_col == c_LAST_COL) begin
            w_col_next = '0;
            w_row_next = out_row + 1'b1;
        end
    end

    sys_array_pace_counter #(
        .CLOCK_DIVIDE (CLOCK_DIVIDE)
    ) u_pace (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_gap_load),
        .i_count_en (r_state == ST_GAP),
        .o_expire   (w_gap_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < c_ELEMS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            drain_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (comp_done) begin
                        for (int i = 0; i < c_ELEMS; i++) begin
                            r_buf[i] <= res_data[i*RES_WIDTH +: RES_WIDTH];
                        end
                        // Element 0 comes straight from the bus so it can be
                        // presented on the very next cycle.
                        out_data  <= res_data[0 +: RES_WIDTH];
                        out_row   <= '0;
                        out_col   <= '0;
                        r_idx     <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        overrun   <= 1'b0;
                        r_state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (comp_done) begin
                        overrun <= 1'b1;
                    end
                    if (w_handshake) begin
                        if (w_last) begin
                            out_valid  <= 1'b0;
                            busy       <= 1'b0;
                            drain_done <= 1'b1;
                            r_idx      <= '0;
                            out_row    <= '0;
                            out_col    <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            // Next element is loaded now; in the paced case it
                            // simply waits behind out_valid=0 for the gap.
                            r_idx    <= w_idx_next;
                            out_row  <= w_row_next;
                            out_col  <= w_col_next;
                            out_data <= r_buf[w_idx_next];
                            if (CLOCK_DIVIDE == 0) begin
                                out_valid <= 1'b1;
                                r_state   <= ST_SEND;
                            end else begin
                                out_valid <= 1'b0;
                                r_state   <= ST_GAP;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (comp_done) begin
                        overrun <= 1'b1;
                    end
                    if (w_gap_expire) begin
                        out_valid <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_array_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_array_result_reader
// Description : Self-checking bench for sys_array_result_reader. Two
//               instances: CLOCK_DIVIDE=2 (paced) and CLOCK_DIVIDE=0
//               (back-to-back). The expected stream is derived from the
//               matrix held in the bench: element k is mat[k] at row k/L,
//               col k%L, spaced by 2**CLOCK_DIVIDE-1 idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_array_result_reader;

    localparam int RW   = 32;
    localparam int AW   = 4;
    localparam int AL   = 4;
    localparam int N    = AW * AL;
    localparam int CD_A = 2;
    localparam int CD_B = 0;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          comp_done = 1'b0;
    logic          out_ready = 1'b0;
    logic          sel       = 1'b0;
    logic [N*RW-1:0] res_data = '0;

    logic          cd_a, cd_b;
    logic          va, vb, ba, bb, dda, ddb, oa, ob;
    logic [RW-1:0] da, db;
    logic [1:0]    ra, rb, ca, cb;

    logic          o_valid, o_busy, o_dd, o_ovr;
    logic [RW-1:0] o_data;
    logic [1:0]    o_row, o_col;

    int            total   = 0;
    int            bad     = 0;
    int            gap     = (1 << CD_A) - 1;
    bit            exp_ovr = 1'b0;
    logic [RW-1:0] mat [N];

    assign cd_a = comp_done & ~sel;
    assign cd_b = comp_done & sel;

    assign o_valid = sel ? vb  : va;
    assign o_busy  = sel ? bb  : ba;
    assign o_dd    = sel ? ddb : dda;
    assign o_ovr   = sel ? ob  : oa;
    assign o_data  = sel ? db  : da;
    assign o_row   = sel ? rb  : ra;
    assign o_col   = sel ? cb  : ca;

    always #5 clk = ~clk;

    sys_array_result_reader #(.CLOCK_DIVIDE(CD_A)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .comp_done  (cd_a),
        .res_data   (res_data),
        .out_ready  (out_ready),
        .out_valid  (va),
        .out_data   (da),
        .out_row    (ra),
        .out_col    (ca),
        .busy       (ba),
        .drain_done (dda),
        .overrun    (oa)
    );

    sys_array_result_reader #(.CLOCK_DIVIDE(CD_B)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .comp_done  (cd_b),
        .res_data   (res_data),
        .out_ready  (out_ready),
        .out_valid  (vb),
        .out_data   (db),
        .out_row    (rb),
        .out_col    (cb),
        .busy       (bb),
        .drain_done (ddb),
        .overrun    (ob)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the selected instance against the expected cycle state.
    task automatic chk_state(input string tag, input bit ev, input int k,
                             input bit eb, input bit edd);
        chk($sformatf("%s.valid@%0d", tag, k), 32'(o_valid), 32'(ev));
        chk($sformatf("%s.busy@%0d",  tag, k), 32'(o_busy),  32'(eb));
        chk($sformatf("%s.ddone@%0d", tag, k), 32'(o_dd),    32'(edd));
        chk($sformatf("%s.ovr@%0d",   tag, k), 32'(o_ovr),   32'(exp_ovr));
        if (ev) begin
            chk($sformatf("%s.data@%0d", tag, k), o_data,          mat[k]);
            chk($sformatf("%s.row@%0d",  tag, k), 32'(o_row),      32'(k / AL));
            chk($sformatf("%s.col@%0d",  tag, k), 32'(o_col),      32'(k % AL));
        end
    endtask

    // All outputs at their reset value, data and indices included.
    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".busy"},  32'(o_busy),  32'd0);
        chk({tag, ".ddone"}, 32'(o_dd),    32'd0);
        chk({tag, ".ovr"},   32'(o_ovr),   32'd0);
        chk({tag, ".data"},  o_data,       32'd0);
        chk({tag, ".row"},   32'(o_row),   32'd0);
        chk({tag, ".col"},   32'(o_col),   32'd0);
    endtask

    task automatic fill_seq();
        for (int i = 0; i < N; i++) mat[i] = 32'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) mat[i] = $urandom;
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < N; i++) res_data[i*RW +: RW] = $urandom;
    endtask

    // Pulse comp_done with mat on the bus; returns at the next negedge.
    task automatic start();
        for (int i = 0; i < N; i++) res_data[i*RW +: RW] = mat[i];
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        exp_ovr   = 1'b0;
        scramble_bus();
    endtask

    // Drain one matrix. Called at the negedge where element 0 must be valid.
    task automatic drain(input string tag, input int stall_k, input int stall_n,
                         input bit rand_stall, input int ovr_at,
                         input int abort_at, input bit b2b);
        int n;
        bit pulse;
        for (int k = 0; k < N; k++) begin
            n = (k == stall_k) ? stall_n :
                (rand_stall ? int'($urandom_range(0, 2)) : 0);
            out_ready = 1'b0;
            for (int s = 0; s < n; s++) begin
                chk_state(tag, 1'b1, k, 1'b1, 1'b0);
                @(negedge clk);
            end
            chk_state(tag, 1'b1, k, 1'b1, 1'b0);
            out_ready = 1'b1;
            scramble_bus();
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (k == N - 1) begin
                chk_state(tag, 1'b0, 0, 1'b0, 1'b1);
                if (b2b) begin
                    fill_rand();
                    start();
                end else begin
                    @(negedge clk);
                    chk_state(tag, 1'b0, 0, 1'b0, 1'b0);
                end
            end else begin
                for (int g = 0; g < gap; g++) begin
                    chk_state(tag, 1'b0, k, 1'b1, 1'b0);
                    if (k == abort_at && g == 0) begin
                        #2 reset_n = 1'b0;
                        #1;
                        exp_ovr = 1'b0;
                        chk_zero({tag, ".async"});
                        @(negedge clk);
                        reset_n   = 1'b1;
                        out_ready = 1'b0;
                        return;
                    end
                    pulse = (k == ovr_at && g == 0);
                    if (pulse) begin
                        comp_done = 1'b1;
                        scramble_bus();
                    end
                    @(negedge clk);
                    if (pulse) begin
                        comp_done = 1'b0;
                        exp_ovr   = 1'b1;
                    end
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values on both instances while reset is held.
        repeat (2) @(negedge clk);
        chk_zero("rst_a");
        sel = 1'b1;
        #1;
        chk_zero("rst_b");
        sel = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_state("idle", 1'b0, 0, 1'b0, 1'b0);

        // Paced drain of 1..16 with a permanently ready consumer.
        fill_seq();
        start();
        drain("seq", -1, 0, 1'b0, -1, -1, 1'b0);

        // Five-cycle stall on element 5 (row 1, col 1).
        fill_seq();
        start();
        drain("bp", 5, 5, 1'b0, -1, -1, 1'b0);

        // comp_done during the gap after element 3, then a clean capture.
        fill_rand();
        start();
        drain("ovr", -1, 0, 1'b1, 3, -1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk_state("ovr_idle", 1'b0, 0, 1'b0, 1'b0);
        end
        fill_rand();
        start();
        drain("ovr_clr", -1, 0, 1'b0, -1, -1, 1'b0);

        // Asynchronous reset in the gap after element 7.
        fill_rand();
        start();
        drain("abort", -1, 0, 1'b0, -1, 7, 1'b0);
        repeat (4) begin
            chk_state("post_abort", 1'b0, 0, 1'b0, 1'b0);
            @(negedge clk);
        end
        fill_rand();
        start();
        drain("fresh", -1, 0, 1'b0, -1, -1, 1'b0);

        // New capture in the drain_done cycle.
        fill_rand();
        start();
        drain("b2b1", -1, 0, 1'b0, -1, -1, 1'b1);
        drain("b2b2", -1, 0, 1'b1, -1, -1, 1'b0);

        // Unpaced instance: one element per cycle, then random stalls.
        @(negedge clk);
        sel = 1'b1;
        gap = (1 << CD_B) - 1;
        fill_rand();
        start();
        drain("cd0", -1, 0, 1'b0, -1, -1, 1'b0);
        fill_rand();
        start();
        drain("cd0_rs", -1, 0, 1'b1, -1, -1, 1'b1);
        drain("cd0_b2b", -1, 0, 1'b1, -1, -1, 1'b0);

        // Paced instance with random stalls.
        @(negedge clk);
        sel = 1'b0;
        gap = (1 << CD_A) - 1;
        repeat (2) begin
            fill_rand();
            start();
            drain("rand", -1, 0, 1'b1, -1, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sys_array_result_reader.md
Name: sys_array_result_reader

Overview:
- Drains the result matrix of the systolic array after a computation finishes. Sits downstream of the array, opposite to the parameter/start side.
- Captures the full ARRAY_W x ARRAY_L result matrix on a done pulse.
- Streams the matrix out one element at a time, in row-major order, over a valid/ready interface.
- Paces the stream with a programmable inter-element gap, so a slow consumer such as the hex display driver can follow it.

Parameters:
- DATA_WIDTH, 8, operand width of the array.
- RES_WIDTH, 4*DATA_WIDTH, width of one result element; matches the hex display bus.
- ARRAY_W, 4, number of result rows.
- ARRAY_L, 4, number of result columns.
- CLOCK_DIVIDE, 2, sets the inter-element gap to 2**CLOCK_DIVIDE-1 idle cycles; 0 means back-to-back.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- comp_done  in  1  single-cycle pulse from the array: result matrix valid this cycle
- res_data  in  ARRAY_W*ARRAY_L*RES_WIDTH  flat matrix; element (r,c) at bits [(r*ARRAY_L+c)*RES_WIDTH +: RES_WIDTH]
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data/out_row/out_col valid
- out_data  out  RES_WIDTH  current element
- out_row  out  $clog2(ARRAY_W) (min 1)  row index of current element
- out_col  out  $clog2(ARRAY_L) (min 1)  column index of current element
- busy  out  1  a drain is in progress
- drain_done  out  1  one-cycle pulse after the last element is accepted
- overrun  out  1  sticky flag: comp_done arrived while busy

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - out_valid, busy, drain_done and overrun are 0.
  - out_data, out_row and out_col are 0.
  - Capture buffer cleared; gap counter and element index are 0.
- States: IDLE, SEND, GAP.
- IDLE:
  - comp_done=1 registers all of res_data into the internal buffer and clears overrun.
  - Next cycle: state SEND, busy=1, out_valid=1, element 0 presented (out_row=0, out_col=0).
  - Latency from comp_done to first out_valid is 1 cycle.
- SEND:
  - out_valid held at 1; data and indices stay stable until out_valid & out_ready.
  - On a handshake that is not the last element: increment the index, row-major (col wraps at ARRAY_L-1 to 0 and row increments).
    - CLOCK_DIVIDE>0: go to GAP with out_valid=0.
    - CLOCK_DIVIDE=0: stay in SEND with the next element presented the following cycle.
  - On the handshake of element ARRAY_W*ARRAY_L-1: go to IDLE. Next cycle drain_done=1 for exactly 1 cycle, busy=0, out_valid=0, index reset to 0.
- GAP:
  - Counts 2**CLOCK_DIVIDE-1 cycles with out_valid=0, then returns to SEND with the next element.
  - out_ready is ignored in GAP.
- comp_done while busy (SEND or GAP, including the cycle of the final handshake):
  - Ignored for capture; the buffer is unchanged.
  - overrun set to 1 and held until the next accepted capture or reset.
- comp_done in the same cycle drain_done is high: state is IDLE, so it is accepted as a new capture.
- The buffer is frozen during a drain; res_data changes mid-drain have no effect.
- out_ready held low in SEND stalls indefinitely; there is no timeout.
- reset_n asserted mid-drain aborts immediately to the reset values; no drain_done pulse.

Decomposition:
- Package sys_array_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - a helper function for the index width, max(1, $clog2(n));
  - a localparam for the element count (ARRAY_W*ARRAY_L).
- One sub-module, sys_array_pace_counter: a loadable down-counter that generates the GAP expiry strobe from CLOCK_DIVIDE. Everything else stays in the top module.

Test Plan:
- Default params. Reset, then comp_done with element i = i+1 (0x00000001..0x00000010), out_ready=1.
  - out_valid rises 1 cycle after comp_done.
  - 16 elements 0x1..0x10 in row-major order, consecutive valids 4 cycles apart.
  - drain_done 1 cycle after the 16th handshake.
- Backpressure: out_ready low for 5 cycles on element 5 (row 1, col 1).
  - out_data stays 0x00000006 with out_row=1, out_col=1.
  - Order is otherwise unchanged.
- Overrun: comp_done pulsed during GAP after element 3.
  - overrun=1 and stays 1; drained data unchanged.
  - The next comp_done in IDLE clears overrun and restarts from element 0.
- CLOCK_DIVIDE=0, out_ready=1: 16 elements on 16 consecutive cycles, then drain_done.
- Async reset mid-drain after element 7: all outputs go to 0 without waiting for a clock edge; no drain_done. A fresh comp_done drains fully from element 0.
- Back-to-back: comp_done in the drain_done cycle is accepted; second matrix drains from element 0 and overrun stays 0.
